// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the registered ALU control stage.
// Encodings here are the contract between control, the ALU and the MDU.
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_ctrl_e;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic {IDLE, MULTI} state_e;

  function automatic alu_ctrl_e mdu_code(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Handshake and decode bus of the ALU control stage.
// The slave side is the stage; the master side is the surrounding pipeline.
interface alu_ctrl_if #(parameter int CTRL_W = 5);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_control;
  logic              is_mdu;
  logic              illegal;
  logic              mdu_busy;

  modport master (
    output flush, in_valid, alu_op, op, funct3, funct7, out_ready,
    input  in_ready, out_valid, alu_control, is_mdu, illegal, mdu_busy
  );

  modport slave (
    input  flush, in_valid, alu_op, op, funct3, funct7, out_ready,
    output in_ready, out_valid, alu_control, is_mdu, illegal, mdu_busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of {alu_op, op, funct3, funct7} into an ALU/MDU code.
// Undecodable encodings raise illegal and fall back to ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_ctrl_e  code,
  output logic       is_mdu,
  output logic       illegal
);

  logic is_r;
  logic f7_zero;
  logic f7_alt;

  assign is_r    = (op == OP_RTYPE);
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == F7_ALT);

  // NOTE: every output gets a default before any branch, so no path leaves one unassigned (no latch).
  always_comb begin
    code    = ALU_ADD;
    is_mdu  = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b11: illegal = 1'b1;
      default: begin
        if (ENABLE_M && is_r && (funct7 == F7_MULDIV)) begin
          code   = mdu_code(funct3);
          is_mdu = 1'b1;
        end else begin
          case (funct3)
            3'b000:  code = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
          // I-type funct7 is immediate except where it selects the shift flavour.
          if (is_r)
            illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
          else
            illegal = ((funct3 == 3'b001) && !f7_zero) ||
                      ((funct3 == 3'b101) && !f7_zero && !f7_alt);
          if (illegal) code = ALU_ADD;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID/EX control register: decodes on accept, holds M ops for MDU_LAT cycles,
// and exposes valid/ready handshakes on both sides.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W   = 5,
  parameter bit ENABLE_M = 1'b1,
  parameter int MDU_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_ctrl_if.slave   bus
);

  localparam int CNT_W       = $clog2(MDU_LAT + 1);
  localparam bit MULTI_CYCLE = (MDU_LAT > 1);

  alu_ctrl_e dec_code;
  logic      dec_is_mdu;
  logic      dec_illegal;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] alu_control_q, alu_control_d;
  logic              is_mdu_q, is_mdu_d;
  logic              illegal_q, illegal_d;
  logic              in_ready;
  logic              accept;

  alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .alu_op  (bus.alu_op),
    .op      (bus.op),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .code    (dec_code),
    .is_mdu  (dec_is_mdu),
    .illegal (dec_illegal)
  );

  // Ready depends only on registered state, out_ready and flush, never on in_valid.
  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    alu_control_d = alu_control_q;
    is_mdu_d      = is_mdu_q;
    illegal_d     = illegal_q;
    if (bus.flush) begin
      // Decoded fields deliberately keep their last values on a kill.
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.out_ready) out_valid_d = 1'b0;
          if (accept) begin
            alu_control_d = CTRL_W'(dec_code);
            is_mdu_d      = dec_is_mdu;
            illegal_d     = dec_illegal;
            if (dec_is_mdu && MULTI_CYCLE) begin
              state_d     = MULTI;
              cnt_d       = CNT_W'(MDU_LAT - 1);
              out_valid_d = 1'b0;
            end else begin
              out_valid_d = 1'b1;
            end
          end
        end
        MULTI: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      alu_control_q <= CTRL_W'(ALU_ADD);
      is_mdu_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      alu_control_q <= alu_control_d;
      is_mdu_q      <= is_mdu_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_control = alu_control_q;
  assign bus.is_mdu      = is_mdu_q;
  assign bus.illegal     = illegal_q;
  assign bus.mdu_busy    = (state_q == MULTI);

endmodule
